bram: RTL and testbench

BRAM -- requirements
Module: bram

---
 rtl/bram.sv | 92 +++++++++
 tb/tb_bram.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bram.sv
// Dual-port, read-first block RAM with a post-reset clear sequence that zeroes
// every word before either port is allowed to access the array.
//   state | meaning
//   CLEAR | sweep counter writes 0 to each word; ports ignored, q held at 0
//   READY | clear finished; both ports active until the next reset
module bram #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] address_a,
    input  logic              wren_a,
    input  logic [DWIDTH-1:0] data_a,
    output logic [DWIDTH-1:0] q_a,
    input  logic [AWIDTH-1:0] address_b,
    input  logic              wren_b,
    input  logic [DWIDTH-1:0] data_b,
    output logic [DWIDTH-1:0] q_b,
    output logic              init_done
);

    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AWIDTH-1:0] clr_cnt;
    logic              clr_last;
    logic              wr_b_en;
    logic [DWIDTH-1:0] mem [DEPTH];

    assign clr_last  = (clr_cnt == {AWIDTH{1'b1}});
    assign init_done = (state == READY);

    // Same-address collision: port A wins, port B's write is dropped.
    assign wr_b_en = wren_b && !(wren_a && (address_a == address_b));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR: if (clr_last) state_next = READY;
            READY: state_next = READY;
        endcase
    end

    // Array has no reset; it is zeroed only by the clear sweep.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (wren_a) begin
                    mem[address_a] <= data_a;
                end
                if (wr_b_en) begin
                    mem[address_b] <= data_b;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_a <= '0;
            q_b <= '0;
        end else if (init_done) begin
            q_a <= mem[address_a];
            q_b <= mem[address_b];
        end else begin
            q_a <= '0;
            q_b <= '0;
        end
    end

endmodule

// File: tb/tb_bram.sv
// Self-checking bench for bram: per-cycle expectations are queued when a
// cycle is driven and popped after the clock edge that produces them.
module tb_bram;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] address_a = '0;
    logic       wren_a = 1'b0;
    logic [7:0] data_a = '0;
    logic [7:0] q_a;
    logic [8:0] address_b = '0;
    logic       wren_b = 1'b0;
    logic [7:0] data_b = '0;
    logic [7:0] q_b;
    logic       init_done;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         ca;
        bit         cb;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [512];

    bram #(.DWIDTH(8), .AWIDTH(9)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address_a(address_a),
        .wren_a   (wren_a),
        .data_a   (data_a),
        .q_a      (q_a),
        .address_b(address_b),
        .wren_b   (wren_b),
        .data_b   (data_b),
        .q_b      (q_b),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Drive one READY-state cycle; queue read-first expectations, then update the model.
    task automatic drive(input logic [8:0] aa, input logic wa, input logic [7:0] da,
                         input logic [8:0] ab, input logic wb, input logic [7:0] db,
                         input bit ca, input bit cb);
        exp_t e;
        address_a = aa; wren_a = wa; data_a = da;
        address_b = ab; wren_b = wb; data_b = db;
        e.a = model[aa]; e.b = model[ab]; e.ca = ca; e.cb = cb;
        sb.push_back(e);
        if (wb && !(wa && aa == ab)) model[ab] = db;
        if (wa) model[aa] = da;
        @(posedge clk); #1;
        wren_a = 1'b0; wren_b = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 512; i++) model[i] = 8'h00;
    endtask

    // Counts edges after reset release until init_done; bounded.
    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        logic [8:0] addrs [3];
        addrs[0] = 9'h000; addrs[1] = 9'h1FF; addrs[2] = 9'h0AB;
        reset_n = 1'b0;
        #1;
        checks++; if (q_a !== 8'h00 || q_b !== 8'h00) $display("FAIL reset_q q_a=%h q_b=%h required 00/00", q_a, q_b); else passed++;
        checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done got %b required 0", init_done); else passed++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_init(n);
        checks++; if (n !== 512) $display("FAIL clear_length got %0d cycles required 512", n); else passed++;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            drive(addrs[i], 1'b0, 8'h00, 9'h000, 1'b0, 8'h00, 1'b1, 1'b0);
            e = sb.pop_front();
            checks++; if (q_a !== e.a) $display("FAIL post_clear_read addr=%h got %h required %h", addrs[i], q_a, e.a); else passed++;
        end
    endtask

    task automatic test_a_write_b_read();
        exp_t e;
        drive(9'h010, 1'b1, 8'h5A, 9'h000, 1'b0, 8'h00, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(9'h000, 1'b0, 8'h00, 9'h010, 1'b0, 8'h00, 1'b0, 1'b1);
        e = sb.pop_front();
        checks++; if (q_b !== e.b || q_b !== 8'h5A) $display("FAIL a_write_b_read got %h required 5a", q_b); else passed++;
    endtask

    task automatic test_read_during_write();
        exp_t e;
        drive(9'h020, 1'b1, 8'h11, 9'h000, 1'b0, 8'h00, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(9'h020, 1'b1, 8'h22, 9'h020, 1'b0, 8'h00, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++; if (q_a !== e.a || q_a !== 8'h11) $display("FAIL rdw_same_port got %h required 11", q_a); else passed++;
        checks++; if (q_b !== e.b || q_b !== 8'h11) $display("FAIL rdw_cross_port got %h required 11", q_b); else passed++;
        drive(9'h020, 1'b0, 8'h00, 9'h020, 1'b0, 8'h00, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++; if (q_a !== e.a || q_a !== 8'h22) $display("FAIL rdw_later_read got %h required 22", q_a); else passed++;
        // Port B writing while A reads the same word: A must still see the old word.
        drive(9'h020, 1'b0, 8'h00, 9'h020, 1'b1, 8'h33, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++; if (q_a !== e.a || q_a !== 8'h22) $display("FAIL rdw_b_write_a_read got %h required 22", q_a); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive(9'h1FF, 1'b1, 8'hAA, 9'h1FF, 1'b1, 8'hBB, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(9'h1FF, 1'b0, 8'h00, 9'h1FF, 1'b0, 8'h00, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++; if (q_a !== e.a || q_a !== 8'hAA) $display("FAIL collision_a_wins got %h required aa", q_a); else passed++;
        drive(9'h030, 1'b1, 8'h01, 9'h031, 1'b1, 8'h02, 1'b0, 1'b0);
        void'(sb.pop_front());
        drive(9'h031, 1'b0, 8'h00, 9'h030, 1'b0, 8'h00, 1'b1, 1'b1);
        e = sb.pop_front();
        checks++; if (q_a !== e.a || q_b !== e.b) $display("FAIL dual_write q_a=%h q_b=%h required %h/%h", q_a, q_b, e.a, e.b); else passed++;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        drive(9'h1FF, 1'b0, 8'h00, 9'h010, 1'b0, 8'h00, 1'b0, 1'b0);
        void'(sb.pop_front());
        reset_n = 1'b0;
        #1;
        checks++; if (q_a !== 8'h00 || q_b !== 8'h00) $display("FAIL async_reset_q q_a=%h q_b=%h required 00/00", q_a, q_b); else passed++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            address_a = 9'h005; data_a = 8'h77; wren_a = (c >= 3 && c <= 20);
            address_b = 9'h006; data_b = 8'h77; wren_b = (c >= 3 && c <= 20);
            @(posedge clk); #1;
            if (c == 10) begin
                checks++; if (q_a !== 8'h00 || q_b !== 8'h00) $display("FAIL clear_q_hold q_a=%h q_b=%h required 00/00", q_a, q_b); else passed++;
            end
        end
        wren_a = 1'b0; wren_b = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if (q_a !== 8'h00 || q_b !== 8'h00 || init_done !== 1'b0) $display("FAIL mid_clear_reset q_a=%h q_b=%h init_done=%b required 00/00/0", q_a, q_b, init_done); else passed++;
        @(posedge clk); #1;
        // Write attempt during the fresh clear, after address 5 was already swept.
        reset_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            address_a = 9'h005; data_a = 8'h77; wren_a = (c == 10);
            @(posedge clk); #1;
        end
        wren_a = 1'b0;
        wait_init(n);
        checks++; if (n !== 502) $display("FAIL restart_clear_length got %0d required 512 total", n + 10); else passed++;
        clear_model();
        drive(9'h005, 1'b0, 8'h00, 9'h006, 1'b0, 8'h00, 1'b1, 1'b1);
        begin
            exp_t e;
            e = sb.pop_front();
            checks++; if (q_a !== e.a || q_b !== e.b) $display("FAIL clear_ignores_write q_a=%h q_b=%h required %h/%h", q_a, q_b, e.a, e.b); else passed++;
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        int   bad = 0;
        logic [8:0] a;
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            drive(a, 1'b1, a[7:0] ^ 8'h3C, 9'h000, 1'b0, 8'h00, 1'b0, 1'b0);
            void'(sb.pop_front());
        end
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            drive(9'h000, 1'b0, 8'h00, a, 1'b0, 8'h00, 1'b0, 1'b1);
            e = sb.pop_front();
            if (q_b !== e.b || q_b !== (a[7:0] ^ 8'h3C)) begin
                if (bad < 4) $display("FAIL sweep_read addr=%h got %h required %h", a, q_b, a[7:0] ^ 8'h3C);
                bad++;
            end
        end
        checks++; if (bad !== 0) $display("FAIL sweep_total got %0d bad words required 0", bad); else passed++;
    endtask

    initial begin
        test_reset();
        test_a_write_b_read();
        test_read_during_write();
        test_back_to_back();
        test_reset_mid_clear();
        test_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
